// File: rtl/auto_exposure_controller.sv
// Mean-luma exposure loop: frame_end at N -> new exposure + ready_update_out at N+3; requests spaced >= 4 cycles, extras merged.
// No backpressure on the pixel stream; AE_STATS_EN adds per-frame stat_sum/stat_cnt/stat_valid outputs.
module auto_exposure_controller #(
  parameter logic [7:0] TARGET_LO     = 8'd100,
  parameter logic [7:0] TARGET_HI     = 8'd140,
  parameter logic [7:0] STEP          = 8'd4,
  parameter logic [7:0] EXP_MIN       = 8'd1,
  parameter logic [7:0] EXP_MAX       = 8'd255,
  parameter logic [7:0] INIT_EXPOSURE = 8'h40,
  parameter int         SETTLE_FRAMES = 2
) (
  input  logic        clk_camera,
  input  logic        sys_rst_camera,
  input  logic        pixel_valid,
  input  logic [7:0]  pixel_luma,
  input  logic        frame_end,
  input  logic [1:0]  mode,
  input  logic [7:0]  manual_value,
  output logic [7:0]  exposure,
  output logic        manual_exposure,
  output logic        ready_update_out
`ifdef AE_STATS_EN
  ,
  output logic [23:0] stat_sum,
  output logic [16:0] stat_cnt,
  output logic        stat_valid
`endif
);

  localparam logic [1:0] ST_WAIT    = 2'd0;
  localparam logic [1:0] ST_COMPARE = 2'd1;
  localparam logic [1:0] ST_UPDATE  = 2'd2;
  localparam logic [1:0] ST_SETTLE  = 2'd3;
  localparam logic [3:0] SETTLE_N   = 4'(SETTLE_FRAMES);

  logic [23:0] acc_sum_q, acc_sum_d, cur_sum;
  logic [16:0] acc_cnt_q, acc_cnt_d, cur_cnt;
  logic        acc_sum_sat_q, acc_sum_sat_d, cur_sum_sat;
  logic        acc_cnt_sat_q, acc_cnt_sat_d, cur_cnt_sat;
  logic [24:0] sum_add;

  logic [23:0] snap_sum_q, snap_sum_d;
  logic [16:0] snap_cnt_q, snap_cnt_d;
  logic        snap_sum_sat_q, snap_sum_sat_d;
  logic        snap_cnt_sat_q, snap_cnt_sat_d;

  logic [1:0]  state_q, state_d;
  logic [3:0]  settle_q, settle_d;
  logic [24:0] lo_q, lo_d, hi_q, hi_d;
  logic [23:0] cmp_sum_q, cmp_sum_d;
  logic [7:0]  exp_q, exp_d;
  logic [8:0]  exp_up, exp_dn;
  logic [7:0]  exp_up_c, exp_dn_c;
  logic        loop_mode, loop_req;

  logic [1:0]  mode_q;
  logic [7:0]  manval_q;
  logic        boot_q;
  logic        chg, new_req;
  logic        pend_q, pend_d;
  logic [1:0]  gap_q, gap_d;
  logic        ready_q, ready_d;
  logic [7:0]  exp_out_q, exp_out_d;
  logic        man_out_q, man_out_d;

  // Pixel coinciding with frame_end belongs to the closing frame.
  always_comb begin
    sum_add     = {1'b0, acc_sum_q} + {17'd0, pixel_luma};
    cur_sum     = acc_sum_q;
    cur_cnt     = acc_cnt_q;
    cur_sum_sat = acc_sum_sat_q;
    cur_cnt_sat = acc_cnt_sat_q;
    if (pixel_valid) begin
      if (sum_add[24]) begin
        cur_sum     = '1;
        cur_sum_sat = 1'b1;
      end else begin
        cur_sum = sum_add[23:0];
      end
      if (acc_cnt_q == '1) begin
        cur_cnt_sat = 1'b1;
      end else begin
        cur_cnt = acc_cnt_q + 17'd1;
      end
    end

    acc_sum_d      = frame_end ? '0   : cur_sum;
    acc_cnt_d      = frame_end ? '0   : cur_cnt;
    acc_sum_sat_d  = frame_end ? 1'b0 : cur_sum_sat;
    acc_cnt_sat_d  = frame_end ? 1'b0 : cur_cnt_sat;
    snap_sum_d     = frame_end ? cur_sum     : snap_sum_q;
    snap_cnt_d     = frame_end ? cur_cnt     : snap_cnt_q;
    snap_sum_sat_d = frame_end ? cur_sum_sat : snap_sum_sat_q;
    snap_cnt_sat_d = frame_end ? cur_cnt_sat : snap_cnt_sat_q;
  end

  always_comb begin
    exp_up   = {1'b0, exp_q} + {1'b0, STEP};
    exp_dn   = {1'b0, exp_q} - {1'b0, STEP};
    exp_up_c = (exp_up > {1'b0, EXP_MAX}) ? EXP_MAX : exp_up[7:0];
    exp_dn_c = (exp_dn[8] || (exp_dn[7:0] < EXP_MIN)) ? EXP_MIN : exp_dn[7:0];
  end

  assign loop_mode = mode[1];

  always_comb begin
    state_d   = state_q;
    settle_d  = settle_q;
    lo_d      = lo_q;
    hi_d      = hi_q;
    cmp_sum_d = cmp_sum_q;
    exp_d     = exp_q;
    loop_req  = 1'b0;

    case (state_q)
      ST_WAIT: begin
        settle_d = '0;
        if (frame_end) state_d = ST_COMPARE;
      end
      ST_COMPARE: begin
        lo_d      = {8'd0, snap_cnt_q} * {17'd0, TARGET_LO};
        hi_d      = {8'd0, snap_cnt_q} * {17'd0, TARGET_HI};
        cmp_sum_d = snap_sum_q;
        if (snap_cnt_q == '0 || snap_sum_sat_q || snap_cnt_sat_q) state_d = ST_WAIT;
        else                                                      state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        if ({1'b0, cmp_sum_q} < lo_q)      exp_d = exp_up_c;
        else if ({1'b0, cmp_sum_q} > hi_q) exp_d = exp_dn_c;
        settle_d = '0;
        if (exp_d != exp_q) begin
          loop_req = 1'b1;
          state_d  = (SETTLE_N == 4'd0) ? ST_WAIT : ST_SETTLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        if (frame_end) begin
          if (settle_q + 4'd1 >= SETTLE_N) begin
            state_d  = ST_WAIT;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 4'd1;
          end
        end
      end
    endcase

    // Leaving loop mode freezes or overrides the loop and aborts any sequence in flight.
    if (!loop_mode) begin
      state_d  = ST_WAIT;
      settle_d = '0;
      loop_req = 1'b0;
    end
    if (mode == 2'd1) exp_d = manual_value;
  end

  // Outputs only move when a request issues, so they stay put through the configurator's write.
  always_comb begin
    chg       = (mode != mode_q) || ((mode == 2'd1) && (manual_value != manval_q));
    new_req   = boot_q || chg || loop_req;
    ready_d   = (pend_q || new_req) && (gap_q == 2'd0);
    pend_d    = (pend_q || new_req) && !ready_d;
    gap_d     = ready_d ? 2'd3 : ((gap_q != 2'd0) ? gap_q - 2'd1 : 2'd0);
    exp_out_d = ready_d ? exp_d : exp_out_q;
    man_out_d = ready_d ? (mode != 2'd0) : man_out_q;
  end

  always_ff @(posedge clk_camera) begin
    if (sys_rst_camera) begin
      acc_sum_q      <= '0;
      acc_cnt_q      <= '0;
      acc_sum_sat_q  <= 1'b0;
      acc_cnt_sat_q  <= 1'b0;
      snap_sum_q     <= '0;
      snap_cnt_q     <= '0;
      snap_sum_sat_q <= 1'b0;
      snap_cnt_sat_q <= 1'b0;
      state_q        <= ST_WAIT;
      settle_q       <= '0;
      lo_q           <= '0;
      hi_q           <= '0;
      cmp_sum_q      <= '0;
      exp_q          <= INIT_EXPOSURE;
      mode_q         <= mode;
      manval_q       <= manual_value;
      boot_q         <= 1'b1;
      pend_q         <= 1'b0;
      gap_q          <= '0;
      ready_q        <= 1'b0;
      exp_out_q      <= INIT_EXPOSURE;
      man_out_q      <= 1'b0;
    end else begin
      acc_sum_q      <= acc_sum_d;
      acc_cnt_q      <= acc_cnt_d;
      acc_sum_sat_q  <= acc_sum_sat_d;
      acc_cnt_sat_q  <= acc_cnt_sat_d;
      snap_sum_q     <= snap_sum_d;
      snap_cnt_q     <= snap_cnt_d;
      snap_sum_sat_q <= snap_sum_sat_d;
      snap_cnt_sat_q <= snap_cnt_sat_d;
      state_q        <= state_d;
      settle_q       <= settle_d;
      lo_q           <= lo_d;
      hi_q           <= hi_d;
      cmp_sum_q      <= cmp_sum_d;
      exp_q          <= exp_d;
      mode_q         <= mode;
      manval_q       <= manual_value;
      boot_q         <= 1'b0;
      pend_q         <= pend_d;
      gap_q          <= gap_d;
      ready_q        <= ready_d;
      exp_out_q      <= exp_out_d;
      man_out_q      <= man_out_d;
    end
  end

  assign exposure         = exp_out_q;
  assign manual_exposure  = man_out_q;
  assign ready_update_out = ready_q;

`ifdef AE_STATS_EN
  logic stat_vld_q;

  always_ff @(posedge clk_camera) begin
    if (sys_rst_camera) stat_vld_q <= 1'b0;
    else                stat_vld_q <= frame_end;
  end

  assign stat_sum   = snap_sum_q;
  assign stat_cnt   = snap_cnt_q;
  assign stat_valid = stat_vld_q;
`endif

endmodule

// File: tb/tb_auto_exposure_controller.sv
// Directed scoreboard bench: expected update requests are queued by stimulus and popped by a negedge monitor.
module tb_auto_exposure_controller;

  logic        clk_camera = 1'b0;
  logic        sys_rst_camera;
  logic        pixel_valid;
  logic [7:0]  pixel_luma;
  logic        frame_end;
  logic [1:0]  mode;
  logic [7:0]  manual_value;
  logic [7:0]  exposure;
  logic        manual_exposure;
  logic        ready_update_out;
`ifdef AE_STATS_EN
  logic [23:0] stat_sum;
  logic [16:0] stat_cnt;
  logic        stat_valid;
`endif

  always #5 clk_camera = ~clk_camera;

  auto_exposure_controller dut (
    .clk_camera       (clk_camera),
    .sys_rst_camera   (sys_rst_camera),
    .pixel_valid      (pixel_valid),
    .pixel_luma       (pixel_luma),
    .frame_end        (frame_end),
    .mode             (mode),
    .manual_value     (manual_value),
    .exposure         (exposure),
    .manual_exposure  (manual_exposure),
    .ready_update_out (ready_update_out)
`ifdef AE_STATS_EN
    ,
    .stat_sum         (stat_sum),
    .stat_cnt         (stat_cnt),
    .stat_valid       (stat_valid)
`endif
  );

  typedef struct {
    logic [7:0] exp;
    logic       man;
    int         cyc;
  } req_t;

  req_t sb_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  int   last_rdy    = -1;

  always @(posedge clk_camera) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_req(input logic [7:0] e, input logic m, input int c);
    req_t r;
    r.exp = e;
    r.man = m;
    r.cyc = c;
    sb_q.push_back(r);
  endtask

  always @(negedge clk_camera) begin
    if (!sys_rst_camera && ready_update_out) begin
      req_t r;
      if (last_rdy >= 0) check("req_spacing_ge4", int'((cyc - last_rdy) >= 4), 1);
      last_rdy = cyc;
      check("request_expected", int'(sb_q.size() > 0), 1);
      if (sb_q.size() > 0) begin
        r = sb_q.pop_front();
        check("req_exposure", int'(exposure), int'(r.exp));
        check("req_manual_exposure", int'(manual_exposure), int'(r.man));
        check("req_cycle", cyc, r.cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk_camera);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic frame(input int n, input logic [7:0] luma, output int fe_cyc);
    fe_cyc = 0;
    for (int i = 0; i < n; i++) begin
      pixel_valid = 1'b1;
      pixel_luma  = luma;
      frame_end   = (i == n - 1);
      if (i == n - 1) fe_cyc = cyc;
      step();
    end
    if (n == 0) begin
      frame_end = 1'b1;
      fe_cyc    = cyc;
      step();
    end
    pixel_valid = 1'b0;
    frame_end   = 1'b0;
  endtask

  initial begin
    int n;
    int m;

    sys_rst_camera = 1'b1;
    pixel_valid    = 1'b0;
    pixel_luma     = 8'd0;
    frame_end      = 1'b0;
    mode           = 2'd2;
    manual_value   = 8'd0;
    idle(3);
    check("reset_exposure", int'(exposure), 8'h40);
    check("reset_manual_exposure", int'(manual_exposure), 0);
    check("reset_ready", int'(ready_update_out), 0);

    // Release: one sync request on the following cycle.
    sys_rst_camera = 1'b0;
    expect_req(8'h40, 1'b1, cyc + 1);
    idle(6);

    // Dark frame: 0x40 -> 0x44 at N+3.
    frame(1000, 8'd50, n);
    expect_req(8'h44, 1'b1, n + 3);
    idle(6);

    // Two settle frames ignored, third evaluated.
    frame(1000, 8'd50, n);
    frame(1000, 8'd50, n);
    frame(1000, 8'd50, n);
    expect_req(8'h48, 1'b1, n + 3);
    idle(6);

    // Upper clamp from 253.
    mode = 2'd1; manual_value = 8'd253; m = cyc;
    expect_req(8'd253, 1'b1, m + 1);
    idle(6);
    mode = 2'd2; m = cyc;
    expect_req(8'd253, 1'b1, m + 1);
    idle(6);
    frame(1000, 8'd50, n);
    expect_req(8'd255, 1'b1, n + 3);
    idle(6);
    frame(1000, 8'd50, n);
    frame(1000, 8'd50, n);
    frame(1000, 8'd50, n);
    idle(6);
    check("clamp_hold_exposure", int'(exposure), 255);

    // In-window frame and empty frame produce nothing.
    frame(1000, 8'd120, n);
    idle(6);
    frame(0, 8'd0, n);
    idle(6);

    // Bright frame steps down.
    frame(1000, 8'd200, n);
    expect_req(8'd251, 1'b1, n + 3);
    idle(8);

    // Manual mode with a value change two cycles later: second request held by spacing.
    mode = 2'd1; manual_value = 8'h22; m = cyc;
    expect_req(8'h22, 1'b1, m + 1);
    idle(2);
    manual_value = 8'h33;
    expect_req(8'h33, 1'b1, m + 5);
    idle(8);
    check("manual_final_exposure", int'(exposure), 8'h33);

    // Back to loop, then abort to sensor AEC while in COMPARE.
    mode = 2'd2; m = cyc;
    expect_req(8'h33, 1'b1, m + 1);
    idle(6);
    frame(1000, 8'd50, n);
    mode = 2'd0;
    expect_req(8'h33, 1'b0, n + 2);
    idle(12);
    check("abort_exposure", int'(exposure), 8'h33);
    check("abort_manual_exposure", int'(manual_exposure), 0);

    check("outstanding_requests", sb_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
